mult_seq: RTL and testbench

- Multi-cycle unsigned 32x32->64 multiplier sequencer implementing MULTU for the MIPS core.
- Runs shift-and-add over a single shared WIDTH-bit adder, one multiplier bit per cycle.
- Writes the product into HI/LO result registers.
- Sits beside the ALU in EX; the core stalls on busy.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_seq_if.sv | 38 +++
 rtl/mult_add_stage.sv | 24 ++
 rtl/mult_seq.sv | 156 +++++++++++++++
 tb/tb_mult_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared constants for the MULT/MULTU sequencer slice.
//   - FSM state encodings (2-bit, kept as plain constants so legacy code that
//     compares raw state values keeps working)
//   - default operand width and iteration-counter width
// Optional feature macro used by the slice: MULT_SIGNED_EN (enables FIX state).
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [1:0] FIX  = 2'd3;

   // Operand width; HI and LO are each this wide.
   localparam int MULT_WIDTH = 32;
   // Iteration counter width; 2**MULT_CNT_W must exceed MULT_WIDTH.
   localparam int MULT_CNT_W = 6;

endpackage : mult_pkg

// File: rtl/mult_seq_if.sv
// ---------------------------------------------------------------------------
// mult_seq_if
// Request/result bundle between the EX stage and the multiply sequencer.
//   start  : request a multiply (sampled only while busy=0)
//   a, b   : multiplicand / multiplier, captured on accept
//   sgn    : (MULT_SIGNED_EN only) 1 = MULT, 0 = MULTU
//   busy   : operation in flight
//   done   : one-cycle pulse, hi/lo valid from this cycle on
//   hi, lo : upper / lower product words
// Modports: master = requester (core), slave = sequencer.
// Optional feature macro: MULT_SIGNED_EN adds the sgn signal.
// ---------------------------------------------------------------------------
interface mult_seq_if
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef MULT_SIGNED_EN
   logic             sgn;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

`ifdef MULT_SIGNED_EN
   modport master (output start, a, b, sgn, input  busy, done, hi, lo);
   modport slave  (input  start, a, b, sgn, output busy, done, hi, lo);
`else
   modport master (output start, a, b, input  busy, done, hi, lo);
   modport slave  (input  start, a, b, output busy, done, hi, lo);
`endif

endinterface : mult_seq_if

// File: rtl/mult_add_stage.sv
// ---------------------------------------------------------------------------
// mult_add_stage
// Combinational WIDTH-bit adder shared by every shift-and-add iteration.
//   a, b  : addends (a is the running accumulator)
//   sum   : a + b modulo 2**WIDTH
//   carry : carry out, recovered by an unsigned compare (sum < a), which is
//           how the core's adder32 exposes its carry.
// ---------------------------------------------------------------------------
module mult_add_stage
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   assign sum   = a + b;
   // A wrapped sum is always smaller than either addend.
   assign carry = (sum < a);

endmodule : mult_add_stage

// File: rtl/mult_seq.sv
// ---------------------------------------------------------------------------
// mult_seq
// Multi-cycle 32x32->64 multiplier (MULTU, optionally MULT) for the EX stage.
// Shift-and-add over a single shared adder, one multiplier bit per cycle.
// The core stalls while busy=1.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : mult_seq_if.slave (start, a, b, [sgn], busy, done, hi, lo)
//
// Timing: start accepted at edge E0, done high in the cycle after E32
// (33 cycles). With MULT_SIGNED_EN a one-cycle FIX state is always inserted
// (34 cycles). hi/lo only change when the result is committed.
//
// Optional feature macro: MULT_SIGNED_EN (signed MULT via magnitude + fix-up).
// ---------------------------------------------------------------------------
module mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = MULT_CNT_W
) (
   input  logic      clk,
   input  logic      reset,
   mult_seq_if.slave bus
);

   logic [1:0]       state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mplr;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;

   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic [WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0] mplr_nx;
   logic             last;

   logic [WIDTH-1:0] a_cap;
   logic [WIDTH-1:0] b_cap;

`ifdef MULT_SIGNED_EN
   logic                 neg;
   logic                 neg_cap;
   logic [2*WIDTH-1:0]   prod;
   logic [2*WIDTH-1:0]   prod_fix;

   // MULT runs on magnitudes; the sign is reapplied in FIX. Negating the
   // most negative value wraps back to itself, which read unsigned is the
   // correct magnitude.
   always_comb begin
      a_cap   = bus.a;
      b_cap   = bus.b;
      neg_cap = 1'b0;
      if (bus.sgn) begin
         if (bus.a[WIDTH-1]) a_cap = '0 - bus.a;
         if (bus.b[WIDTH-1]) b_cap = '0 - bus.b;
         neg_cap = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
   end

   assign prod     = {acc, mplr};
   assign prod_fix = neg ? (~prod + (2*WIDTH)'(1)) : prod;
`else
   assign a_cap = bus.a;
   assign b_cap = bus.b;
`endif

   // Only add the multiplicand when the current multiplier bit is set.
   assign addend = mplr[0] ? mcand : '0;

   mult_add_stage #(
      .WIDTH (WIDTH)
   ) u_add (
      .a     (acc),
      .b     (addend),
      .sum   (sum),
      .carry (carry)
   );

   // {acc, mplr} <= {carry, sum, mplr} >> 1 : product bits shift into mplr
   // as the consumed multiplier bits shift out.
   assign acc_nx  = {carry, sum[WIDTH-1:1]};
   assign mplr_nx = {sum[0], mplr[WIDTH-1:1]};
   assign last    = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         mcand <= '0;
         acc   <= '0;
         mplr  <= '0;
         cnt   <= '0;
         hi_r  <= '0;
         lo_r  <= '0;
`ifdef MULT_SIGNED_EN
         neg   <= 1'b0;
`endif
      end else begin
         case (state)
            // DONE accepts back-to-back exactly like IDLE.
            IDLE, DONE: begin
               if (bus.start) begin
                  mcand <= a_cap;
                  mplr  <= b_cap;
                  acc   <= '0;
                  cnt   <= '0;
`ifdef MULT_SIGNED_EN
                  neg   <= neg_cap;
`endif
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end

            RUN: begin
               acc  <= acc_nx;
               mplr <= mplr_nx;
               cnt  <= cnt + CNT_W'(1);
               if (last) begin
`ifdef MULT_SIGNED_EN
                  state <= FIX;
`else
                  hi_r  <= acc_nx;
                  lo_r  <= mplr_nx;
                  state <= DONE;
`endif
               end
            end

`ifdef MULT_SIGNED_EN
            // Taken for every operation so latency does not depend on sign.
            FIX: begin
               hi_r  <= prod_fix[2*WIDTH-1:WIDTH];
               lo_r  <= prod_fix[WIDTH-1:0];
               state <= DONE;
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state == RUN) || (state == FIX);
   assign bus.done = (state == DONE);
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

endmodule : mult_seq

// File: tb/tb_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_seq
// Scoreboard bench for mult_seq: stimulus pushes hand-computed products and
// the expected done cycle into a queue; a monitor pops and compares on every
// done pulse. Set MULT_SIGNED_EN to also cover the signed path.
// ---------------------------------------------------------------------------
module tb_mult_seq;

   localparam int W = 32;
`ifdef MULT_SIGNED_EN
   localparam int LAT      = 34;
   localparam int BUSY_LEN = 33;
`else
   localparam int LAT      = 33;
   localparam int BUSY_LEN = 32;
`endif

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
   } exp_t;

   logic   clk   = 1'b0;
   logic   reset = 1'b0;
   int     cyc   = 0;
   int     checks = 0;
   int     errors = 0;
   exp_t   sb_q[$];
   logic [W-1:0] prev_hi = '0;
   logic [W-1:0] prev_lo = '0;

   mult_seq_if #(.WIDTH(W)) ifc ();

   mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!reset && ifc.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("hi", 64'(ifc.hi), 64'(e.hi));
            chk("lo", 64'(ifc.lo), 64'(e.lo));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Count busy cycles and confirm hi/lo hold their old values meanwhile.
   task automatic wait_busy(input string tag);
      int nbusy;
      int held_bad;
      nbusy    = 0;
      held_bad = 0;
      while (ifc.busy === 1'b1 && nbusy < 100) begin
         nbusy++;
         if (ifc.hi !== prev_hi || ifc.lo !== prev_lo) held_bad++;
         @(negedge clk);
      end
      chk({tag, "_busy_len"}, 64'(nbusy), 64'(BUSY_LEN));
      chk({tag, "_hold"}, 64'(held_bad), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input logic [W-1:0] eh, input logic [W-1:0] el);
      exp_t e;
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.a     = av;
      ifc.b     = bv;
`ifdef MULT_SIGNED_EN
      ifc.sgn   = sv;
`else
      if (sv) $display("note: %s requests signed on an unsigned build", tag);
`endif
      e.hi = eh; e.lo = el; e.cyc = cyc + LAT;
      sb_q.push_back(e);
      @(negedge clk);
      ifc.start = 1'b0;
      wait_busy(tag);
      prev_hi = eh;
      prev_lo = el;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   n;
      ifc.start = 1'b0;
      ifc.a     = '0;
      ifc.b     = '0;
`ifdef MULT_SIGNED_EN
      ifc.sgn   = 1'b0;
`endif
      #1 reset = 1'b1;
      #2;
      chk("rst_busy", 64'(ifc.busy), 64'd0);
      chk("rst_done", 64'(ifc.done), 64'd0);
      chk("rst_hi",   64'(ifc.hi),   64'd0);
      chk("rst_lo",   64'(ifc.lo),   64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_op("3x5",   32'd3,          32'd5,          1'b0, 32'h0000_0000, 32'h0000_000F);
      run_op("ffxff", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("bzero", 32'h1234_5678,  32'h0000_0000,  1'b0, 32'h0000_0000, 32'h0000_0000);

      // 7x9, an ignored start mid-run, then a back-to-back start in DONE.
      @(negedge clk);
      ifc.start = 1'b1; ifc.a = 32'd7; ifc.b = 32'd9;
      e.hi = '0; e.lo = 32'd63; e.cyc = cyc + LAT;
      sb_q.push_back(e);
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (8) @(negedge clk);
      ifc.start = 1'b1; ifc.a = 32'd1; ifc.b = 32'd1;
      @(negedge clk);
      ifc.start = 1'b0; ifc.a = '0; ifc.b = '0;
      n = 0;
      while (ifc.done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_first_done", 64'(ifc.done), 64'd1);
      ifc.start = 1'b1; ifc.a = 32'd2; ifc.b = 32'd2;
      e.hi = '0; e.lo = 32'd4; e.cyc = cyc + LAT;
      sb_q.push_back(e);
      prev_hi = '0;
      prev_lo = 32'd63;
      @(negedge clk);
      ifc.start = 1'b0;
      wait_busy("b2b");
      prev_hi = '0;
      prev_lo = 32'd4;

      // Reset in the middle of a run: nothing pushed, so any done fails.
      @(negedge clk);
      ifc.start = 1'b1; ifc.a = 32'hFFFF_FFFF; ifc.b = 32'hFFFF_FFFF;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_busy", 64'(ifc.busy), 64'd0);
      chk("midrst_done", 64'(ifc.done), 64'd0);
      chk("midrst_hi",   64'(ifc.hi),   64'd0);
      chk("midrst_lo",   64'(ifc.lo),   64'd0);
      prev_hi = '0;
      prev_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);

      run_op("p16sq", 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000);
      run_op("msbx2", 32'h8000_0000, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h0000_0000);

`ifdef MULT_SIGNED_EN
      run_op("s_m2x3", 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("u_m2x3", 32'hFFFF_FFFE, 32'd3, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
`endif

      repeat (5) @(negedge clk);
      chk("outstanding", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mult_seq
